// File: rtl/cached_mem_subsystem.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of a fixed-latency backing memory.
// Latency: done 2 cycles after acceptance for a load hit or a rejected request, 2+MISS_LAT for a load miss or any store.
// Backpressure: one request in flight; ready drops on accept and load/store are ignored until ready returns.
module cached_mem_subsystem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LINES     = 8,
  parameter int MEM_DEPTH = 256,
  parameter int MISS_LAT  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              store,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              done,
  output logic              hit,
  output logic              err
);

  localparam int IW = $clog2(LINES);
  localparam int MW = $clog2(MEM_DEPTH);
  localparam int TW = MW - IW;
  localparam int CW = $clog2(MISS_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, RESP} state_t;
  typedef logic [DATA_W-1:0] mem_t [MEM_DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < MEM_DEPTH; i++) m[i] = DATA_W'(32'hA500_0000 | 32'(i));
    return m;
  endfunction

  // Backing store is never reset; the power-up image is the only initial content.
  mem_t mem = mem_init();

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              load_q, store_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic [LINES-1:0]  line_vld;
  logic [TW-1:0]     line_tag [LINES];
  logic [DATA_W-1:0] line_dat [LINES];
  logic              res_hit, res_err;
  logic [DATA_W-1:0] res_dat;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [MW-1:0] midx;
  logic          accept, lookup_err, lookup_hit, mem_last;

  assign idx        = addr_q[IW-1:0];
  assign tag        = addr_q[MW-1:IW];
  assign midx       = addr_q[MW-1:0];
  assign accept     = (state == IDLE) && ready && (load || store);
  assign lookup_err = ((addr_q >> MW) != '0) || (load_q && store_q);
  assign lookup_hit = line_vld[idx] && (line_tag[idx] == tag);
  assign mem_last   = (state == MEM_WAIT) && (cnt == CW'(MISS_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = (lookup_err || (load_q && lookup_hit)) ? RESP : MEM_WAIT;
      MEM_WAIT: if (mem_last) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // done is registered out of RESP, so ready stays low through the done cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b1;
      done     <= 1'b0;
      hit      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      addr_q   <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      wdata_q  <= '0;
      cnt      <= '0;
      line_vld <= '0;
      res_hit  <= 1'b0;
      res_err  <= 1'b0;
      res_dat  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        addr_q  <= addr;
        load_q  <= load;
        store_q <= store;
        wdata_q <= wdata;
        ready   <= 1'b0;
        hit     <= 1'b0;
        err     <= 1'b0;
      end else if (state == IDLE && !ready) begin
        ready <= 1'b1;
      end
      case (state)
        LOOKUP: begin
          cnt     <= '0;
          res_err <= lookup_err;
          res_hit <= lookup_hit && !lookup_err;
          if (load_q && lookup_hit) res_dat <= line_dat[idx];
        end
        MEM_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_last && load_q) begin
            line_vld[idx] <= 1'b1;
            res_dat       <= mem[midx];
          end
        end
        RESP: begin
          done <= 1'b1;
          hit  <= res_hit;
          err  <= res_err;
          if (load_q && !res_err) rdata <= res_dat;
        end
        default: ;
      endcase
    end
  end

  // Stores commit only at the end of the wait, so a reset before then leaves memory untouched.
  always_ff @(posedge clk) begin
    if (mem_last) begin
      if (load_q) begin
        line_tag[idx] <= tag;
        line_dat[idx] <= mem[midx];
      end else if (res_hit) begin
        line_dat[idx] <= wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_last && store_q) mem[midx] <= wdata_q;
  end

endmodule

// File: tb/tb_cached_mem_subsystem.sv
// Directed bench for cached_mem_subsystem: latency, hit/miss, eviction, store commit, errors and reset abort.
module tb_cached_mem_subsystem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, done, hit, err;

  int checks = 0;
  int errors = 0;

  cached_mem_subsystem #(
    .ADDR_W(32), .DATA_W(32), .LINES(8), .MEM_DEPTH(256), .MISS_LAT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .load(load), .store(store),
    .wdata(wdata), .rdata(rdata), .ready(ready), .done(done), .hit(hit), .err(err)
  );

  always #5 clk = ~clk;

  // Issues one request and measures edges from acceptance to done; pulses load while busy.
  task automatic do_req(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic h, output logic e,
                        output logic hs_ok);
    int k;
    lat = -1; rd = '0; h = 1'b0; e = 1'b0; hs_ok = 1'b1;
    @(negedge clk);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    load = ld; store = st; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; store = 1'b0;
    for (k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      load = 1'b0;
      if (done) begin
        lat = k; rd = rdata; h = hit; e = err;
        break;
      end
      if (ready) hs_ok = 1'b0;
      load = k[0];
      addr = 32'h7;
    end
    load = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      if (done || !ready) hs_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", hit); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    load = 1'b1; addr = 32'h19;
    @(posedge clk);
    #1 load = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL accept_ready got %b want 0", ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b want 1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_miss_hit();
    int lat; logic [31:0] rd; logic h, e, ok;
    do_req(1'b1, 1'b0, 32'h19, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 22) begin errors++; $display("FAIL cold_lat got %0d want 22", lat); end
    checks++; if (rd !== 32'hA500_0019) begin errors++; $display("FAIL cold_rdata got %h want a5000019", rd); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL cold_hit got %b want 0", h); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cold_handshake got %b want 1", ok); end
    do_req(1'b1, 1'b0, 32'h19, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL hit_lat got %0d want 2", lat); end
    checks++; if (rd !== 32'hA500_0019) begin errors++; $display("FAIL hit_rdata got %h want a5000019", rd); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL hit_hit got %b want 1", h); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hit_handshake got %b want 1", ok); end
  endtask

  task automatic test_evict();
    int lat; logic [31:0] rd; logic h, e, ok;
    do_req(1'b1, 1'b0, 32'h04, 32'h0, lat, rd, h, e, ok);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL ev04_hit got %b want 0", h); end
    do_req(1'b1, 1'b0, 32'h0C, 32'h0, lat, rd, h, e, ok);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL ev0c_hit got %b want 0", h); end
    checks++; if (rd !== 32'hA500_000C) begin errors++; $display("FAIL ev0c_rdata got %h want a500000c", rd); end
    do_req(1'b1, 1'b0, 32'h04, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 22) begin errors++; $display("FAIL evict_lat got %0d want 22", lat); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL evict_hit got %b want 0", h); end
    checks++; if (rd !== 32'hA500_0004) begin errors++; $display("FAIL evict_rdata got %h want a5000004", rd); end
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; logic h, e, ok;
    do_req(1'b0, 1'b1, 32'h19, 32'hDEAD_BEEF, lat, rd, h, e, ok);
    checks++; if (lat !== 22) begin errors++; $display("FAIL sthit_lat got %0d want 22", lat); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL sthit_hit got %b want 1", h); end
    checks++; if (rd !== 32'hA500_0004) begin errors++; $display("FAIL sthit_rdata got %h want a5000004", rd); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sthit_handshake got %b want 1", ok); end
    do_req(1'b1, 1'b0, 32'h19, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld19_lat got %0d want 2", lat); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL ld19_hit got %b want 1", h); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld19_rdata got %h want deadbeef", rd); end
    do_req(1'b0, 1'b1, 32'h30, 32'h1234_5678, lat, rd, h, e, ok);
    checks++; if (lat !== 22) begin errors++; $display("FAIL stmiss_lat got %0d want 22", lat); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL stmiss_hit got %b want 0", h); end
    do_req(1'b1, 1'b0, 32'h30, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 22) begin errors++; $display("FAIL ld30_lat got %0d want 22", lat); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL ld30_hit got %b want 0", h); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ld30_rdata got %h want 12345678", rd); end
  endtask

  task automatic test_err();
    int lat; logic [31:0] rd; logic h, e, ok;
    do_req(1'b1, 1'b0, 32'h100, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oob_lat got %0d want 2", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", e); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL oob_hit got %b want 0", h); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL oob_rdata got %h want 12345678", rd); end
    do_req(1'b1, 1'b0, 32'h30, 32'h0, lat, rd, h, e, ok);
    checks++; if (h !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL post_oob hit/err got %b/%b want 1/0", h, e); end
    do_req(1'b1, 1'b1, 32'h05, 32'hFFFF_FFFF, lat, rd, h, e, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL both_lat got %0d want 2", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL both_err got %b want 1", e); end
    do_req(1'b1, 1'b0, 32'h05, 32'h0, lat, rd, h, e, ok);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", e); end
    checks++; if (rd !== 32'hA500_0005) begin errors++; $display("FAIL both_mem got %h want a5000005", rd); end
  endtask

  task automatic test_reset_mid_store();
    int lat, k; logic [31:0] rd; logic h, e, ok;
    @(negedge clk);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    store = 1'b1; addr = 32'h05; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    store = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midrst ready/done got %b/%b want 1/0", ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b1, 1'b0, 32'h05, 32'h0, lat, rd, h, e, ok);
    checks++; if (lat !== 22) begin errors++; $display("FAIL abort_lat got %0d want 22", lat); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL abort_hit got %b want 0", h); end
    checks++; if (rd !== 32'hA500_0005) begin errors++; $display("FAIL abort_rdata got %h want a5000005", rd); end
    do_req(1'b1, 1'b0, 32'h19, 32'h0, lat, rd, h, e, ok);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL inval_hit got %b want 0", h); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL kept_rdata got %h want deadbeef", rd); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL kept_handshake got %b want 1", ok); end
  endtask

  initial begin
    test_reset();
    test_load_miss_hit();
    test_evict();
    test_store();
    test_err();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
